// File: rtl/wb_pkg.sv
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'b00,
        WB_SEL_MEM     = 2'b01,
        WB_SEL_PC4     = 2'b10,
        WB_SEL_ILLEGAL = 2'b11
    } wb_sel_t;

    localparam logic [2:0] c_funct3_lb  = 3'b000;
    localparam logic [2:0] c_funct3_lh  = 3'b001;
    localparam logic [2:0] c_funct3_lw  = 3'b010;
    localparam logic [2:0] c_funct3_lbu = 3'b100;
    localparam logic [2:0] c_funct3_lhu = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HALT  = 2'd2
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_ext.sv
// ============================================================================
//  Module      : wb_load_ext
//  Description : Load-data alignment and sign/zero extension with fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_ext
    import wb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_data,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_data[7:0];
            2'd1:    w_byte = i_mem_data[15:8];
            2'd2:    w_byte = i_mem_data[23:16];
            default: w_byte = i_mem_data[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    end

    always_comb begin
        o_data  = '0;
        o_fault = 1'b0;
        case (i_funct3)
            c_funct3_lb:  o_data = {{24{w_byte[7]}}, w_byte};
            c_funct3_lbu: o_data = {24'd0, w_byte};
            c_funct3_lh: begin
                o_data  = {{16{w_half[15]}}, w_half};
                o_fault = i_addr_lo[0];
            end
            c_funct3_lhu: begin
                o_data  = {16'd0, w_half};
                o_fault = i_addr_lo[0];
            end
            c_funct3_lw: begin
                o_data  = i_mem_data;
                o_fault = (i_addr_lo != 2'd0);
            end
            default: o_fault = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage: result select, register-file write port,
//                decode forwarding and fault halt. Optional WB_INSTRET_EN
//                adds a 64-bit retired-instruction counter (o_instret).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import wb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_regWrite,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_wbSel,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_aluResult,
    input  logic [31:0] i_memData,
    input  logic [31:0] i_pcPlus4,
`ifdef WB_INSTRET_EN
    output logic [63:0] o_instret,
`endif
    output logic        o_wrSig,
    output logic [4:0]  o_wrReg,
    output logic [31:0] o_wrData,
    output logic        o_en_WB,
    output logic        o_fwdValid,
    output logic [4:0]  o_fwdReg,
    output logic [31:0] o_fwdData,
    output logic        o_retire,
    output logic        o_halted
);

    wb_state_t   r_state;
    logic        r_en;
    logic        r_wr_sig;
    logic [4:0]  r_wr_reg;
    logic [31:0] r_wr_data;
    logic        r_halted;

    logic [31:0] w_load_data;
    logic        w_load_fault;
    logic [31:0] w_result;
    logic        w_illegal;

    wb_load_ext u_load_ext (
        .i_funct3   (i_funct3),
        .i_addr_lo  (i_addrLo),
        .i_mem_data (i_memData),
        .o_data     (w_load_data),
        .o_fault    (w_load_fault)
    );

    always_comb begin
        w_result  = i_aluResult;
        w_illegal = 1'b0;
        case (wb_sel_t'(i_wbSel))
            WB_SEL_ALU: w_result = i_aluResult;
            WB_SEL_MEM: begin
                w_result  = w_load_data;
                w_illegal = w_load_fault;
            end
            WB_SEL_PC4: w_result = i_pcPlus4;
            default:    w_illegal = 1'b1;
        endcase
    end

    // HALT is only reachable through a handshake and only reset leaves it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_wr_sig  <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    if (i_valid && w_illegal) begin
                        r_state  <= ST_HALT;
                        r_en     <= 1'b0;
                        r_wr_sig <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (i_valid) begin
                        r_state   <= ST_WRITE;
                        r_en      <= 1'b1;
                        r_wr_sig  <= i_regWrite && (i_rd != 5'd0);
                        r_wr_reg  <= i_rd;
                        r_wr_data <= w_result;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_en     <= 1'b0;
                        r_wr_sig <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_HALT;
                    r_en     <= 1'b0;
                    r_wr_sig <= 1'b0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instret <= '0;
        end else if (r_en) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign o_instret = r_instret;
`endif

    assign o_ready    = (r_state != ST_HALT);
    assign o_en_WB    = r_en;
    assign o_retire   = r_en;
    assign o_wrSig    = r_wr_sig;
    assign o_wrReg    = r_wr_reg;
    assign o_wrData   = r_wr_data;
    assign o_fwdValid = r_wr_sig;
    assign o_fwdReg   = r_wr_reg;
    assign o_fwdData  = r_wr_data;
    assign o_halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus4;
    logic        wr_sig;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        en_wb;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        retire;
    logic        halted;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_pass = 0;
    int n_checks = 0;

    // expected architectural view
    bit          m_en;
    bit          m_sig;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_halted;
    longint unsigned m_instret;

    always #5 clk = ~clk;

    wb_stage dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_regWrite  (reg_write),
        .i_rd        (rd),
        .i_wbSel     (wb_sel),
        .i_funct3    (funct3),
        .i_addrLo    (addr_lo),
        .i_aluResult (alu_result),
        .i_memData   (mem_data),
        .i_pcPlus4   (pc_plus4),
`ifdef WB_INSTRET_EN
        .o_instret   (instret),
`endif
        .o_wrSig     (wr_sig),
        .o_wrReg     (wr_reg),
        .o_wrData    (wr_data),
        .o_en_WB     (en_wb),
        .o_fwdValid  (fwd_valid),
        .o_fwdReg    (fwd_reg),
        .o_fwdData   (fwd_data),
        .o_retire    (retire),
        .o_halted    (halted)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void ref_result(output bit legal, output logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        legal = 1'b1;
        d     = 32'd0;
        b     = (mem_data >> (8 * addr_lo)) & 32'hFF;
        h     = (mem_data >> (16 * addr_lo[1])) & 32'hFFFF;
        case (wb_sel)
            2'b00: d = alu_result;
            2'b10: d = pc_plus4;
            2'b01: begin
                case (funct3)
                    3'b000: d = (b >= 128) ? b - 32'd256 : b;
                    3'b100: d = b;
                    3'b001: begin d = (h >= 32768) ? h - 32'd65536 : h; legal = (addr_lo % 2 == 0); end
                    3'b101: begin d = h; legal = (addr_lo % 2 == 0); end
                    3'b010: begin d = mem_data; legal = (addr_lo == 0); end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        bit          legal;
        logic [31:0] d;
        ref_result(legal, d);
        if (rst) begin
            m_en = 0; m_sig = 0; m_reg = '0; m_data = '0; m_halted = 0; m_instret = 0;
        end else begin
            if (m_en) m_instret++;
            if (m_halted || !valid) begin
                m_en = 0; m_sig = 0;
            end else if (!legal) begin
                m_en = 0; m_sig = 0; m_halted = 1;
            end else begin
                m_en = 1; m_sig = reg_write && (rd != 0); m_reg = rd; m_data = d;
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("en_WB", 64'(en_wb), 64'(m_en));
        check("retire", 64'(retire), 64'(m_en));
        check("wrSig", 64'(wr_sig), 64'(m_sig));
        check("fwdValid", 64'(fwd_valid), 64'(m_sig));
        check("wrReg", 64'(wr_reg), 64'(m_reg));
        check("fwdReg", 64'(fwd_reg), 64'(m_reg));
        check("wrData", 64'(wr_data), 64'(m_data));
        check("fwdData", 64'(fwd_data), 64'(m_data));
        check("halted", 64'(halted), 64'(m_halted));
        check("ready", 64'(ready), 64'(!m_halted));
`ifdef WB_INSTRET_EN
        check("instret", instret, m_instret);
`endif
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] r, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4);
        rst = 0; valid = v; reg_write = rw; rd = r; wb_sel = sel; funct3 = f3;
        addr_lo = alo; alu_result = alu; mem_data = mem; pc_plus4 = pc4;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_en = 0; m_sig = 0; m_reg = '0; m_data = '0; m_halted = 0; m_instret = 0;
        idle();
        rst = 1;
        step();
        step();
        check("reset_wrData", 64'(wr_data), 64'h0);

        // LB, byte 2 of 0x12803456 sign-extends 0x80
        drive(1, 1, 5, 2'b01, 3'b000, 2, 0, 32'h12803456, 0);
        step();
        check("lb_data", 64'(wr_data), 64'hFFFFFF80);
        check("lb_reg", 64'(wr_reg), 64'd5);
        // LHU upper half
        drive(1, 1, 6, 2'b01, 3'b101, 2, 0, 32'hBEEF1234, 0);
        step();
        check("lhu_data", 64'(wr_data), 64'h0000BEEF);
        // LW aligned
        drive(1, 1, 7, 2'b01, 3'b010, 0, 0, 32'hDEADBEEF, 0);
        step();
        check("lw_data", 64'(wr_data), 64'hDEADBEEF);
        idle();
        step();

        // Fresh reset so the instret count below starts from zero
        rst = 1;
        step();
        drive(1, 1, 1, 2'b00, 0, 0, 32'h11, 0, 0);
        step();
        check("b2b0_data", 64'(fwd_data), 64'h11);
        drive(1, 1, 2, 2'b10, 0, 0, 0, 0, 32'h104);
        step();
        check("b2b1_data", 64'(fwd_data), 64'h104);
        drive(1, 1, 3, 2'b00, 0, 0, 32'h33, 0, 0);
        step();
        check("b2b2_data", 64'(fwd_data), 64'h33);
        check("b2b2_en", 64'(en_wb), 64'd1);
        idle();
        step();
`ifdef WB_INSTRET_EN
        check("instret3", instret, 64'd3);
`endif

        // rd = 0 retires but does not write
        drive(1, 1, 0, 2'b00, 0, 0, 32'hFFFF, 0, 0);
        step();
        check("rd0_wrSig", 64'(wr_sig), 64'd0);
        check("rd0_retire", 64'(retire), 64'd1);

        // Misaligned LW halts; the stage ignores further traffic
        drive(1, 1, 9, 2'b01, 3'b010, 1, 0, 32'hCAFEF00D, 0);
        step();
        check("mis_halted", 64'(halted), 64'd1);
        drive(1, 1, 4, 2'b00, 0, 0, 32'h55, 0, 0);
        step();
        step();
        check("halt_en", 64'(en_wb), 64'd0);
        idle();
        rst = 1;
        step();
        check("post_halt_ready", 64'(ready), 64'd1);

        // Reset during WRITE discards the captured instruction
        drive(1, 1, 8, 2'b00, 0, 0, 32'hABCD, 0, 0);
        step();
        rst = 1;
        step();
        check("rst_write_en", 64'(en_wb), 64'd0);
        // Reset together with a handshake ignores the handshake
        drive(1, 1, 8, 2'b00, 0, 0, 32'h1234, 0, 0);
        rst = 1;
        step();
        check("rst_hs_data", 64'(wr_data), 64'h0);

        // Randomised traffic with occasional illegal instructions
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 5'($urandom),
                  ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 2) % 2 + (($urandom_range(0, 4) == 0) ? 1 : 0)),
                  2'($urandom), $urandom, $urandom, $urandom);
            if (m_halted && $urandom_range(0, 2) == 0) rst = 1;
            else if (!m_halted && $urandom_range(0, 60) == 0) rst = 1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
